alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Command buffer and issue sequencer that feeds the combinational 8-bit ALU stage and collects its result.
- Accepts {A, B, select} commands over valid/ready and queues them in a small FIFO.
- Drives them onto the ALU operand/select inputs one at a time, then registers `sum_f1` into a result valid/ready interface.
- The ALU stage re-evaluates only on a select transition, so each issue is preceded by a priming cycle.

Parameters:
- DATA_W, 8, operand/result width.
- SEL_W, 3, ALU select width.
- DEPTH, 4, command FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; registered, equals (cmd_count < DEPTH).
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_sel  in  SEL_W  ALU operation select.
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_select  out  SEL_W  to ALU select.
- alu_result  in  DATA_W  from ALU `sum_f1`.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured ALU result.
- res_sel  out  SEL_W  select that produced res_data.
- cmd_count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  (state != IDLE) or (cmd_count != 0).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE; FIFO pointers and count = 0; FIFO contents don't-care.
  - alu_a, alu_b, alu_select, res_data, res_sel = 0.
  - res_valid = 0; cmd_ready = 1; busy = 0.
- Reset mid-operation: an in-flight command, the queued commands and any held result are discarded with no partial output. Outputs take their reset values after the edge.
- Push: on an edge with cmd_valid && cmd_ready, write the head-of-tail entry.
  - cmd_ready is low when full, even if a pop occurs on the same edge (no push-through when full).
- Pop: only as specified by the FSM. Push and pop may occur on the same edge when 0 < count < DEPTH; count is unchanged in that case.
- Pointers wrap modulo DEPTH.
- FSM states: IDLE, PRIME, ISSUE, WAIT.
  - IDLE:
    - count != 0 → pop head into alu_a/alu_b.
    - Drive alu_select = ~head.sel and latch head.sel internally.
    - Go to PRIME.
  - PRIME: alu_select = latched sel → ISSUE. This forces a select transition so the ALU recomputes.
  - ISSUE: ALU has settled for one cycle.
    - On the edge: res_data <= alu_result, res_sel <= latched sel, res_valid <= 1.
    - Go to WAIT.
  - WAIT: alu_* held stable; res_data and res_sel held stable while res_valid && !res_ready.
    - Handshake with count != 0 → res_valid <= 0, pop next command as in IDLE, go to PRIME.
    - Handshake with count == 0 → res_valid <= 0, go to IDLE.
- Latency: command accepted on edge E0 into an empty FIFO while IDLE → pop at E1 → ISSUE at E2 → res_valid high after E3.
- Throughput: one result per 3 cycles with res_ready held high.
- Arithmetic/width: the block performs no arithmetic on data. Results pass through at DATA_W unmodified, with no sign or width changes.
- Ordering: results emerge strictly in command-acceptance order.

Test Plan:
1. Single command A=8'h05, B=8'h03, sel=3'b000, with res_ready=1 → res_valid high exactly 3 cycles after acceptance; res_data=8'h08, res_sel=3'b000; busy returns to 0 one cycle after the handshake.
2. Two back-to-back commands with identical sel=3'b001, (A=8'd10, B=8'd3) then (A=8'd20, B=8'd5) → results 8'd7 then 8'd15. alu_select must show 3'b110 for one cycle before each 3'b001.
3. res_ready=0; push commands every cycle → first command moves to execution, cmd_count saturates at 4, cmd_ready drops and stays low. res_data is held stable for 10+ cycles. Releasing res_ready drains all 5 results in order.
4. rst asserted for one cycle while in ISSUE with 2 commands queued → next cycle: res_valid=0, cmd_count=0, cmd_ready=1, busy=0, alu_select=0. No stale result appears afterwards.
5. Push 10 commands (sel cycling 000..111, wraps FIFO pointers), with res_ready toggling randomly → all 10 results correct per ALU function and in order. No drops or duplicates; a push-pop on the same edge leaves cmd_count unchanged.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Queues {A, B, select} commands in a small FIFO and issues them one at a
//   time to a combinational ALU stage. The result is captured into a
//   valid/ready output register. The ALU only re-evaluates when its select
//   changes, so every issue first drives the inverted select for one cycle
//   (PRIME) and then the real select (ISSUE).
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   cmd_valid/ready   command handshake (cmd_ready is registered)
//   cmd_a/b/sel       command operands and ALU select
//   alu_a/b/select    operands and select driven to the ALU
//   alu_result        ALU output
//   res_valid/ready   result handshake
//   res_data/sel      captured result and the select that produced it
//   cmd_count         FIFO occupancy
//   busy              sequencer active or commands queued
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DATA_W-1:0]        cmd_a,
    input  logic [DATA_W-1:0]        cmd_b,
    input  logic [SEL_W-1:0]         cmd_sel,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    output logic [SEL_W-1:0]         alu_select,
    input  logic [DATA_W-1:0]        alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [DATA_W-1:0]        res_data,
    output logic [SEL_W-1:0]         res_sel,
    output logic [$clog2(DEPTH):0]   cmd_count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, PRIME, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   fifo_a_q [DEPTH];
    logic [DATA_W-1:0]   fifo_b_q [DEPTH];
    logic [SEL_W-1:0]    fifo_s_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                res_valid_q, res_valid_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [SEL_W-1:0]    res_sel_q, res_sel_d;
    logic                push;
    logic                pop;

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        sel_d       = sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;

        // cmd_ready is registered, so a full FIFO never accepts even if it pops.
        push = cmd_valid && cmd_ready_q;

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = PRIME;
                end
            end
            PRIME: begin
                alu_sel_d = sel_q;
                state_d   = ISSUE;
            end
            ISSUE: begin
                res_data_d  = alu_result;
                res_sel_d   = sel_q;
                res_valid_d = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = PRIME;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Load the head entry; the inverted select guarantees a transition in PRIME.
        if (pop) begin
            alu_a_d   = fifo_a_q[rd_ptr_q];
            alu_b_d   = fifo_b_q[rd_ptr_q];
            sel_d     = fifo_s_q[rd_ptr_q];
            alu_sel_d = ~fifo_s_q[rd_ptr_q];
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        cmd_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            sel_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            sel_q       <= sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= cmd_a;
            fifo_b_q[wr_ptr_q] <= cmd_b;
            fifo_s_q[wr_ptr_q] <= cmd_sel;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_sel    = res_sel_q;
    assign cmd_count  = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a stub ALU that recomputes only on a select
// change, plus a queue-based model of accepted commands and FIFO occupancy.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [2:0] cmd_sel = '0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_select;
    logic [7:0] alu_result = '0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [2:0] res_sel;
    logic [2:0] cmd_count;
    logic       busy;

    alu_issue_ctrl #(.DATA_W(8), .SEL_W(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_sel(res_sel),
        .cmd_count(cmd_count), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return ~(a | b);
        endcase
    endfunction

    // ALU stage that only re-evaluates when its select changes.
    always @(alu_select) alu_result = alu_fn(alu_a, alu_b, alu_select);

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] got_q[$];
    int         cnt_exp = 0;
    bit         eng = 0;
    int         total = 0;
    int         bad = 0;

    // One clock: sample handshakes before the edge, update the model after it.
    task automatic cycle();
        logic       push, hs, r, pop;
        logic [7:0] pa, pb, rd;
        logic [2:0] ps, rs;
        exp_t       e;
        push = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
        hs   = (res_valid === 1'b1) && (res_ready === 1'b1);
        r    = rst;
        pa = cmd_a; pb = cmd_b; ps = cmd_sel;
        rd = res_data; rs = res_sel;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            cnt_exp = 0;
            eng = 0;
        end else begin
            if (hs) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_result: got data=%0h sel=%0d, required no result", rd, rs);
                end else begin
                    e = exp_q.pop_front();
                    got_q.push_back(rd);
                    if (rd !== e.d || rs !== e.s) begin
                        bad++;
                        $display("FAIL result: got data=%0h sel=%0d, required data=%0h sel=%0d",
                                 rd, rs, e.d, e.s);
                    end
                end
            end
            if (push) begin
                e.d = alu_fn(pa, pb, ps);
                e.s = ps;
                exp_q.push_back(e);
            end
            // Engine takes the next queued command whenever it is free or its result leaves.
            pop = (cnt_exp > 0) && (!eng || hs);
            if (pop) eng = 1;
            else if (hs) eng = 0;
            cnt_exp = cnt_exp + int'(push) - int'(pop);
            total++;
            if (cmd_count !== 3'(cnt_exp) || cmd_ready !== (cnt_exp < 4)) begin
                bad++;
                $display("FAIL occupancy: got count=%0d ready=%b, required count=%0d ready=%b",
                         cmd_count, cmd_ready, cnt_exp, (cnt_exp < 4));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b count=%0d, required 1 0 0 0",
                     cmd_ready, res_valid, busy, cmd_count);
        end
        total++;
        if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_select !== 3'd0 ||
            res_data !== 8'h00 || res_sel !== 3'd0) begin
            bad++;
            $display("FAIL reset_data: got a=%0h b=%0h sel=%0d rd=%0h rs=%0d, required all 0",
                     alu_a, alu_b, alu_select, res_data, res_sel);
        end
    endtask

    task automatic test_single();
        logic [1:0] vexp [3] = '{1'b0, 1'b0, 1'b1};
        got_q.delete();
        res_ready = 1'b1;
        cmd_a = 8'h05; cmd_b = 8'h03; cmd_sel = 3'b000; cmd_valid = 1'b1;
        cycle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++;
            if (res_valid !== vexp[i][0]) begin
                bad++;
                $display("FAIL single_latency: cycle %0d got res_valid=%b, required %b",
                         i + 1, res_valid, vexp[i][0]);
            end
        end
        total++;
        if (res_data !== 8'h08 || res_sel !== 3'b000) begin
            bad++;
            $display("FAIL single_data: got %0h/%0d, required 08/0", res_data, res_sel);
        end
        cycle();
        total++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got busy=%b valid=%b, required 0 0", busy, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] prev;
        int         primes = 0;
        got_q.delete();
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 8'd10; cmd_b = 8'd3; cmd_sel = 3'b001;
        prev = alu_select;
        cycle();
        cmd_a = 8'd20; cmd_b = 8'd5;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) cmd_valid = 1'b0;
            if (alu_select === 3'b001 && prev !== 3'b001) begin
                total++;
                primes++;
                bad++;
                $display("FAIL prime_missing: select went %0d -> 1, required 6 -> 1", prev);
            end
            prev = alu_select;
            cycle();
            if (alu_select === 3'b001 && prev !== 3'b001) begin
                total++;
                primes++;
                if (prev !== 3'b110) begin
                    bad++;
                    $display("FAIL prime_value: select went %0d -> 1, required 6 -> 1", prev);
                end
            end
            prev = alu_select;
        end
        total++;
        if (primes != 2) begin
            bad++;
            $display("FAIL prime_count: got %0d issues of sel 1, required 2", primes);
        end
        total++;
        if (got_q.size() != 2 || got_q[0] !== 8'd7 || got_q[1] !== 8'd15) begin
            bad++;
            $display("FAIL b2b_results: got %0d results, required 07 then 0f", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held = '0;
        bit         have = 0;
        int         held_cycles = 0;
        got_q.delete();
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 3'($urandom);
            cycle();
            if (res_valid === 1'b1) begin
                if (!have) begin
                    held = res_data;
                    have = 1;
                end else begin
                    held_cycles++;
                    total++;
                    if (res_data !== held) begin
                        bad++;
                        $display("FAIL hold_data: got %0h, required %0h", res_data, held);
                    end
                end
            end
        end
        total++;
        if (cmd_count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1 || held_cycles < 10) begin
            bad++;
            $display("FAIL full: got count=%0d ready=%b valid=%b held=%0d, required 4 0 1 >=10",
                     cmd_count, cmd_ready, res_valid, held_cycles);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 60 && got_q.size() < 5; i++) cycle();
        total++;
        if (got_q.size() != 5 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d results (%0d pending), required 5 (0)",
                     got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        got_q.delete();
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 3'($urandom);
            cycle();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        total++;
        if (res_valid !== 1'b0 || cmd_count !== 3'd0 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || alu_select !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got valid=%b count=%0d ready=%b busy=%b sel=%0d, required 0 0 1 0 0",
                     res_valid, cmd_count, cmd_ready, busy, alu_select);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 15; i++) cycle();
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL stale_result: got %0d results after reset, required 0", got_q.size());
        end
    endtask

    task automatic test_random_wrap();
        logic [7:0] av [10];
        logic [7:0] bv [10];
        int         n = 0;
        logic       acc;
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
        end
        for (int c = 0; c < 400 && got_q.size() < 10; c++) begin
            cmd_valid = (n < 10) && ($urandom_range(0, 3) != 0);
            if (n < 10) begin
                cmd_a = av[n]; cmd_b = bv[n]; cmd_sel = 3'(n % 8);
            end
            res_ready = 1'($urandom_range(0, 1));
            acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
            cycle();
            if (acc) n++;
        end
        cmd_valid = 1'b0;
        total++;
        if (n != 10 || got_q.size() != 10 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_wrap: got pushed=%0d results=%0d pending=%0d, required 10 10 0",
                     n, got_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
